dram_responder: RTL and testbench

Wait-stated data RAM responder for the CPU memory bus. It is the target side of the HTRANS/HADDR/HWRITE/HWDATA request interface that the memory controller drives toward memory. The existing internal ROM answers combinationally; this block answers with a configurable latency and stalls the controller through `HREADY`. It supports byte, half, word and doubleword stores, and it flags misaligned or out-of-range accesses on `HRESP`.

---
 rtl/dram_responder.sv | 141 ++++++++++++++
 tb/tb_dram_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// Wait-stated data RAM target for the CPU memory bus: latched request, configurable
// stall via HREADY, byte/half/word/dword stores and alignment/range errors on HRESP.
module dram_responder #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HTRANS,
    input  logic [63:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HSIZE,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int unsigned IDX_BITS  = ADDR_BITS - 3;
    localparam int unsigned DEPTH     = 1 << IDX_BITS;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [63:0]   lat_addr;
    logic [63:0]   lat_wdata;
    logic          lat_write;
    logic [1:0]    lat_size;
    logic [63:0]   mem [DEPTH];

    logic                accept;
    logic                fast_done;
    logic                to_done;
    logic [63:0]         r_addr;
    logic [63:0]         r_wdata;
    logic                r_write;
    logic [1:0]          r_size;
    logic [2:0]          off;
    logic [3:0]          nbytes;
    logic [2:0]          size_mask;
    logic                err;
    logic [IDX_BITS-1:0] idx;
    logic [63:0]         wdata_sh;
    logic [7:0]          lane_en;
    logic                wr_en;

    // Resolve the request entering DONE; with no wait states it comes straight off the bus.
    always_comb begin
        accept    = HTRANS && HREADY;
        fast_done = NO_WAIT && accept;
        to_done   = fast_done || (state == ST_WAIT && cnt == 4'd0);
        r_addr    = fast_done ? HADDR  : lat_addr;
        r_wdata   = fast_done ? HWDATA : lat_wdata;
        r_write   = fast_done ? HWRITE : lat_write;
        r_size    = fast_done ? HSIZE  : lat_size;
        off       = r_addr[2:0];
        nbytes    = 4'd1 << r_size;
        size_mask = 3'(nbytes - 4'd1);
        err       = ((off & size_mask) != 3'd0) || ((r_addr >> ADDR_BITS) != 64'd0);
        idx       = r_addr[ADDR_BITS-1:3];
        wdata_sh  = r_wdata << {off, 3'b000};
        lane_en   = '0;
        for (int i = 0; i < 8; i++) begin
            lane_en[i] = (4'(i) >= {1'b0, off}) && (4'(i) < ({1'b0, off} + nbytes));
        end
        wr_en     = to_done && r_write && !err;
    end

    // Control FSM and registered bus outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            HREADY    <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 64'd0;
            lat_addr  <= 64'd0;
            lat_wdata <= 64'd0;
            lat_write <= 1'b0;
            lat_size  <= 2'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        lat_addr  <= HADDR;
                        lat_wdata <= HWDATA;
                        lat_write <= HWRITE;
                        lat_size  <= HSIZE;
                        if (NO_WAIT) begin
                            state  <= ST_DONE;
                            HREADY <= 1'b1;
                        end else begin
                            state  <= ST_WAIT;
                            cnt    <= WAIT_LOAD;
                            HREADY <= 1'b0;
                        end
                    end else begin
                        state  <= ST_IDLE;
                        HREADY <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= ST_DONE;
                        HREADY <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    HREADY <= 1'b1;
                end
            endcase

            HRESP <= to_done ? err : 1'b0;
            if (to_done) begin
                if (err) begin
                    HRDATA <= 64'd0;
                end else if (!r_write) begin
                    HRDATA <= mem[idx];
                end
            end
        end
    end

    // Byte-lane store, committed on the edge that enters DONE; contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (lane_en[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: a W=2 instance and a W=0 instance checked
// against a byte-addressed memory model.
module tb_dram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        htrans, hwrite, hready, hresp;
    logic [1:0]  hsize;
    logic [63:0] haddr, hwdata, hrdata;
    logic        b_htrans, b_hwrite, b_hready, b_hresp;
    logic [1:0]  b_hsize;
    logic [63:0] b_haddr, b_hwdata, b_hrdata;

    dram_responder #(.ADDR_BITS(12), .WAIT_CYCLES(2)) dut (
        .CLK(clk), .RESET(rst_n), .HTRANS(htrans), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HWDATA(hwdata), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
    );

    dram_responder #(.ADDR_BITS(12), .WAIT_CYCLES(0)) dut0 (
        .CLK(clk), .RESET(rst_n), .HTRANS(b_htrans), .HADDR(b_haddr), .HWRITE(b_hwrite),
        .HSIZE(b_hsize), .HWDATA(b_hwdata), .HRDATA(b_hrdata), .HREADY(b_hready), .HRESP(b_hresp)
    );

    int errors = 0;
    int checks = 0;

    // Reference: one byte array per instance, plus the last value each put on HRDATA.
    logic [7:0]  mb [2][4096];
    logic [63:0] exp_rd [2];

    function automatic void mdl(input int u, input bit wr, input logic [1:0] sz,
                                input logic [63:0] a, input logic [63:0] wd,
                                output logic [63:0] rd, output logic rsp);
        int n = 1 << sz;
        int base = int'(a[11:0]);
        rsp = ((a % 64'(n)) != 64'd0) || (a >= 64'd4096);
        if (rsp) begin
            exp_rd[u] = 64'd0;
        end else if (wr) begin
            for (int b = 0; b < n; b++) mb[u][base + b] = wd[8*b +: 8];
        end else begin
            for (int b = 0; b < 8; b++) exp_rd[u][8*b +: 8] = mb[u][(base & ~7) + b];
        end
        rd = exp_rd[u];
    endfunction

    int acc_cnt = 0;
    int done_cnt = 0;
    logic prev_ready = 1'b1;
    always @(posedge clk) if (rst_n && htrans && hready) acc_cnt++;
    always @(negedge clk) begin
        if (hready && !prev_ready) done_cnt++;
        prev_ready = hready;
    end

    task automatic access2(input bit wr, input logic [1:0] sz, input logic [63:0] a,
                           input logic [63:0] wd, output logic [63:0] rd,
                           output logic rsp, output int stalls);
        int guard = 0;
        @(negedge clk);
        htrans = 1'b1; hwrite = wr; hsize = sz; haddr = a; hwdata = wd;
        while (hready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        htrans = 1'b0; haddr = {$urandom, $urandom}; hwdata = {$urandom, $urandom};
        hwrite = 1'($urandom); hsize = 2'($urandom);
        stalls = 0;
        while (hready !== 1'b1 && stalls < 20) begin stalls++; @(negedge clk); end
        if (guard >= 20 || stalls >= 20) begin
            checks++; errors++;
            $display("FAIL access_timeout: HREADY stuck for addr %h", a);
        end
        rd = hrdata; rsp = hresp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        htrans = 0; hwrite = 0; hsize = 0; haddr = 0; hwdata = 0;
        b_htrans = 0; b_hwrite = 0; b_hsize = 0; b_haddr = 0; b_hwdata = 0;
        exp_rd[0] = 64'd0; exp_rd[1] = 64'd0;
        repeat (3) @(negedge clk);
        checks++; if (hready !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b want 1", hready); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", hresp); end
        checks++; if (hrdata !== 64'd0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", hrdata); end
        checks++; if (b_hready !== 1'b1) begin errors++; $display("FAIL reset_hready_w0: got %b want 1", b_hready); end
        checks++; if (b_hrdata !== 64'd0) begin errors++; $display("FAIL reset_hrdata_w0: got %h want 0", b_hrdata); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Runs a table of accesses on the W=2 instance, checking data, response and stall count.
    task automatic test_dword();
        logic [63:0] rd, e; logic rsp, er; int st;
        access2(1'b1, 2'd3, 64'h10, 64'h1122334455667788, rd, rsp, st);
        mdl(0, 1'b1, 2'd3, 64'h10, 64'h1122334455667788, e, er);
        checks++; if (st !== 2) begin errors++; $display("FAIL dword_store_stall: got %0d want 2", st); end
        checks++; if (rsp !== er) begin errors++; $display("FAIL dword_store_resp: got %b want %b", rsp, er); end
        access2(1'b0, 2'd3, 64'h10, 64'h0, rd, rsp, st);
        mdl(0, 1'b0, 2'd3, 64'h10, 64'h0, e, er);
        checks++; if (st !== 2) begin errors++; $display("FAIL dword_load_stall: got %0d want 2", st); end
        checks++; if (rsp !== 1'b0) begin errors++; $display("FAIL dword_load_resp: got %b want 0", rsp); end
        checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL dword_load_data: got %h want 1122334455667788", rd); end
        checks++; if (rd !== e) begin errors++; $display("FAIL dword_load_model: got %h want %h", rd, e); end
    endtask

    task automatic test_merge_and_errors();
        bit          wr_t [7] = '{1, 1, 1, 0, 1, 0, 0};
        logic [1:0]  sz_t [7] = '{3, 0, 1, 3, 1, 3, 3};
        logic [63:0] a_t  [7] = '{'h20, 'h23, 'h26, 'h20, 'h21, 'h20, 'h1000};
        logic [63:0] d_t  [7] = '{0, 'hAB, 'hCDEF, 0, 'hFFFF, 0, 0};
        logic [63:0] rd, e; logic rsp, er; int st;
        for (int i = 0; i < 7; i++) begin
            access2(wr_t[i], sz_t[i], a_t[i], d_t[i], rd, rsp, st);
            mdl(0, wr_t[i], sz_t[i], a_t[i], d_t[i], e, er);
            checks++; if (rsp !== er) begin errors++; $display("FAIL merge_resp[%0d]: got %b want %b", i, rsp, er); end
            checks++; if (rd !== e) begin errors++; $display("FAIL merge_data[%0d]: got %h want %h", i, rd, e); end
            if (i == 3) begin
                checks++; if (rd !== 64'hCDEF0000AB000000) begin errors++; $display("FAIL merge_literal: got %h want cdef0000ab000000", rd); end
            end
            if (i == 4) begin
                checks++; if (rsp !== 1'b1) begin errors++; $display("FAIL misaligned_resp: got %b want 1", rsp); end
            end
            if (i == 5) begin
                checks++; if (rd !== 64'hCDEF0000AB000000) begin errors++; $display("FAIL misaligned_unchanged: got %h want cdef0000ab000000", rd); end
            end
            if (i == 6) begin
                checks++; if (rsp !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL range_err: got resp %b data %h want 1 / 0", rsp, rd); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit          wr_t [4] = '{1, 0, 1, 0};
        logic [1:0]  sz_t [4] = '{3, 3, 1, 3};
        logic [63:0] a_t  [4] = '{'h40, 'h40, 'h42, 'h40};
        logic [63:0] d_t  [4] = '{'h0123456789ABCDEF, 0, 'hBEEF, 0};
        logic [63:0] e; logic er;
        @(negedge clk);
        b_htrans = 1; b_hwrite = wr_t[0]; b_hsize = sz_t[0]; b_haddr = a_t[0]; b_hwdata = d_t[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mdl(1, wr_t[i], sz_t[i], a_t[i], d_t[i], e, er);
            checks++; if (b_hready !== 1'b1) begin errors++; $display("FAIL b2b_hready[%0d]: got %b want 1", i, b_hready); end
            checks++; if (b_hrdata !== e || b_hresp !== er) begin errors++; $display("FAIL b2b_done[%0d]: got %h/%b want %h/%b", i, b_hrdata, b_hresp, e, er); end
            if (i < 3) begin
                b_hwrite = wr_t[i+1]; b_hsize = sz_t[i+1]; b_haddr = a_t[i+1]; b_hwdata = d_t[i+1];
            end else begin
                b_htrans = 0;
            end
        end
        checks++; if (b_hrdata !== 64'h01234567BEEFCDEF) begin errors++; $display("FAIL b2b_literal: got %h want 01234567beefcdef", b_hrdata); end
    endtask

    task automatic test_toggle_in_wait();
        int acc0, done0, guard;
        logic [63:0] e; logic er;
        @(negedge clk); #2;
        acc0 = acc_cnt; done0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            htrans = 1; hwrite = 0; hsize = 3; haddr = 64'h10;
            @(posedge clk);
            @(negedge clk);
            guard = 0;
            while (hready === 1'b0 && guard < 20) begin
                htrans = 1'($urandom); hwrite = 1'($urandom);
                haddr = 64'($urandom_range(0, 255)); hwdata = {$urandom, $urandom};
                @(negedge clk); guard++;
            end
            htrans = 0;
            mdl(0, 1'b0, 2'd3, 64'h10, 64'h0, e, er);
            checks++; if (hrdata !== e || hresp !== er) begin errors++; $display("FAIL toggle_data[%0d]: got %h/%b want %h/%b", k, hrdata, hresp, e, er); end
        end
        @(negedge clk); #2;
        checks++; if (acc_cnt - acc0 !== 3) begin errors++; $display("FAIL toggle_accepts: got %0d want 3", acc_cnt - acc0); end
        checks++; if (done_cnt - done0 !== 3) begin errors++; $display("FAIL toggle_completions: got %0d want 3", done_cnt - done0); end
    endtask

    task automatic test_random();
        logic [63:0] rd, e, a, d; logic rsp, er; int st; bit wr; logic [1:0] sz;
        for (int i = 0; i < 32; i++) begin
            d = {$urandom, $urandom};
            access2(1'b1, 2'd3, 64'(i * 8), d, rd, rsp, st);
            mdl(0, 1'b1, 2'd3, 64'(i * 8), d, e, er);
            checks++; if (rsp !== er) begin errors++; $display("FAIL rand_init_resp[%0d]: got %b want %b", i, rsp, er); end
        end
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom); sz = 2'($urandom); d = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a = (64'd1 << $urandom_range(12, 63)) | 64'($urandom_range(0, 7));
            else a = 64'($urandom_range(0, 255));
            access2(wr, sz, a, d, rd, rsp, st);
            mdl(0, wr, sz, a, d, e, er);
            checks++; if (rsp !== er) begin errors++; $display("FAIL rand_resp[%0d]: got %b want %b", i, rsp, er); end
            checks++; if (rd !== e) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, rd, e); end
            checks++; if (st !== 2) begin errors++; $display("FAIL rand_stall[%0d]: got %0d want 2", i, st); end
        end
    endtask

    task automatic test_reset_abort();
        logic [63:0] rd, e; logic rsp, er; int st;
        access2(1'b1, 2'd3, 64'h30, 64'hA5A5A5A5_5A5A5A5A, rd, rsp, st);
        mdl(0, 1'b1, 2'd3, 64'h30, 64'hA5A5A5A5_5A5A5A5A, e, er);
        @(negedge clk);
        htrans = 1; hwrite = 1; hsize = 3; haddr = 64'h30; hwdata = 64'hDEADBEEF_CAFEF00D;
        @(posedge clk);
        @(negedge clk);
        htrans = 0;
        checks++; if (hready !== 1'b0) begin errors++; $display("FAIL abort_in_wait: got %b want 0", hready); end
        rst_n = 1'b0;
        #1;
        checks++; if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 64'd0) begin
            errors++; $display("FAIL abort_reset_outputs: got %b/%b/%h want 1/0/0", hready, hresp, hrdata);
        end
        exp_rd[0] = 64'd0; exp_rd[1] = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        access2(1'b0, 2'd3, 64'h30, 64'h0, rd, rsp, st);
        mdl(0, 1'b0, 2'd3, 64'h30, 64'h0, e, er);
        checks++; if (rd !== 64'hA5A5A5A5_5A5A5A5A || rd !== e) begin errors++; $display("FAIL abort_no_write: got %h want a5a5a5a55a5a5a5a", rd); end
    endtask

    initial begin
        test_reset();
        test_dword();
        test_merge_and_errors();
        test_back_to_back();
        test_toggle_in_wait();
        test_random();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
